// File: rtl/ntt_fifo_writer.sv
// Producer side of a myFIFO_NTT buffer: streams one polynomial per command into
// the dual-port FIFO RAM (even/odd lines per beat), then commits it with wr_finish.
module ntt_fifo_writer #(
  parameter int LINE_SIZE     = 4,
  parameter int BIT_WIDTH     = 54,
  parameter int ADDR_WIDTH    = 9,
  parameter int RLWE_ID_WIDTH = 3,
  parameter int OPCODE_WIDTH  = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [4:0]                           log2_len,
  input  logic                                 cmd_valid,
  output logic                                 cmd_ready,
  input  logic [RLWE_ID_WIDTH-1:0]             cmd_rlwe_id,
  input  logic                                 cmd_poly_id,
  input  logic [OPCODE_WIDTH-1:0]              cmd_opcode,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [2*LINE_SIZE*BIT_WIDTH-1:0]     in_data,
  input  logic                                 fifo_full,
  output logic [ADDR_WIDTH-1:0]                addrA,
  output logic [ADDR_WIDTH-1:0]                addrB,
  output logic [LINE_SIZE*BIT_WIDTH-1:0]       dA,
  output logic [LINE_SIZE*BIT_WIDTH-1:0]       dB,
  output logic [LINE_SIZE-1:0]                 word_selA,
  output logic [LINE_SIZE-1:0]                 word_selB,
  output logic                                 wr_finish,
  output logic [RLWE_ID_WIDTH-1:0]             rlwe_id,
  output logic                                 poly_id,
  output logic [OPCODE_WIDTH-1:0]              opcode,
  output logic                                 busy
);

  localparam int LINE_W = LINE_SIZE * BIT_WIDTH;
  localparam int SHIFT  = $clog2(2 * LINE_SIZE);
  localparam int CNT_W  = ADDR_WIDTH - 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_SPACE,
    WRITE,
    COMMIT,
    SETTLE
  } state_t;

  state_t                     state_q, state_d;
  logic [CNT_W-1:0]           beat_q, beat_d;
  logic                       cmd_ready_q, cmd_ready_d;
  logic                       busy_q, busy_d;
  logic                       wr_finish_q, wr_finish_d;
  logic [RLWE_ID_WIDTH-1:0]   rlwe_id_q, rlwe_id_d;
  logic                       poly_id_q, poly_id_d;
  logic [OPCODE_WIDTH-1:0]    opcode_q, opcode_d;

  logic [31:0]                n_beats;
  logic                       last_beat;
  logic                       fire;

  // Lengths shorter than one beat yield zero beats: the buffer is committed empty.
  always_comb begin
    n_beats = '0;
    if (log2_len >= 5'(SHIFT)) n_beats = 32'd1 << (log2_len - 5'(SHIFT));
  end

  assign last_beat = (32'(beat_q) == (n_beats - 32'd1));
  assign fire      = (state_q == WRITE) && in_valid;

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    rlwe_id_d = rlwe_id_q;
    poly_id_d = poly_id_q;
    opcode_d  = opcode_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          rlwe_id_d = cmd_rlwe_id;
          poly_id_d = cmd_poly_id;
          opcode_d  = cmd_opcode;
          beat_d    = '0;
          state_d   = WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        if (!fifo_full) state_d = (n_beats == 32'd0) ? COMMIT : WRITE;
      end
      // fifo_full is deliberately ignored here: space was confirmed before beat 0.
      WRITE: begin
        if (in_valid) begin
          if (last_beat) state_d = COMMIT;
          else           beat_d  = beat_q + 1'b1;
        end
      end
      COMMIT:  state_d = SETTLE;
      SETTLE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
    wr_finish_d = (state_d != COMMIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      wr_finish_q <= 1'b1;
      rlwe_id_q   <= '0;
      poly_id_q   <= 1'b0;
      opcode_q    <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      wr_finish_q <= wr_finish_d;
      rlwe_id_q   <= rlwe_id_d;
      poly_id_q   <= poly_id_d;
      opcode_q    <= opcode_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign wr_finish = wr_finish_q;
  assign rlwe_id   = rlwe_id_q;
  assign poly_id   = poly_id_q;
  assign opcode    = opcode_q;

  // Write port signals are zero whenever no beat is accepted this cycle.
  assign in_ready  = (state_q == WRITE);
  assign word_selA = {LINE_SIZE{fire}};
  assign word_selB = {LINE_SIZE{fire}};
  assign addrA     = fire ? {beat_q, 1'b0} : '0;
  assign addrB     = fire ? {beat_q, 1'b1} : '0;
  assign dA        = fire ? in_data[LINE_W-1:0] : '0;
  assign dB        = fire ? in_data[2*LINE_W-1:LINE_W] : '0;

endmodule

// File: tb/tb_ntt_fifo_writer.sv
// Directed bench for ntt_fifo_writer: drives commands/beats on the falling edge,
// checks outputs 1 ns later, and compares a captured RAM image to the expected lines.
module tb_ntt_fifo_writer;

  typedef logic [431:0] val_t;

  logic         clk;
  logic         rst;
  logic [4:0]   log2_len;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_rlwe_id;
  logic         cmd_poly_id;
  logic [3:0]   cmd_opcode;
  logic         in_valid;
  logic         in_ready;
  logic [431:0] in_data;
  logic         fifo_full;
  logic [8:0]   addrA;
  logic [8:0]   addrB;
  logic [215:0] dA;
  logic [215:0] dB;
  logic [3:0]   word_selA;
  logic [3:0]   word_selB;
  logic         wr_finish;
  logic [2:0]   rlwe_id;
  logic         poly_id;
  logic [3:0]   opcode;
  logic         busy;

  int           total_cnt = 0;
  int           bad_cnt   = 0;
  int           cycle_cnt = 0;
  int           low_cyc[$];
  logic         low_pid[$];
  logic [215:0] ram_img [0:511];

  ntt_fifo_writer dut (
    .clk        (clk),
    .rst        (rst),
    .log2_len   (log2_len),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_rlwe_id(cmd_rlwe_id),
    .cmd_poly_id(cmd_poly_id),
    .cmd_opcode (cmd_opcode),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .fifo_full  (fifo_full),
    .addrA      (addrA),
    .addrB      (addrB),
    .dA         (dA),
    .dB         (dB),
    .word_selA  (word_selA),
    .word_selB  (word_selB),
    .wr_finish  (wr_finish),
    .rlwe_id    (rlwe_id),
    .poly_id    (poly_id),
    .opcode     (opcode),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Record every commit cycle (wr_finish low) with the tag shown at that time.
  always @(negedge clk) begin
    if (!rst && !wr_finish) begin
      low_cyc.push_back(cycle_cnt);
      low_pid.push_back(poly_id);
    end
  end

  task automatic checkOutput(input string tag, input val_t obs, input val_t exp);
    total_cnt++;
    if (obs !== exp) begin
      bad_cnt++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Coefficient c of the polynomial carries the value c ^ constant.
  function automatic val_t beat_data(input int k);
    val_t r;
    r = '0;
    for (int j = 0; j < 8; j++) r[j*54 +: 54] = 54'(k * 8 + j) ^ 54'h2A5A5A5A5A5A5;
    return r;
  endfunction

  function automatic logic [215:0] golden_line(input int l);
    val_t r;
    r = beat_data(l / 2);
    return (l % 2 == 1) ? r[431:216] : r[215:0];
  endfunction

  task automatic applyStimulus(input int l2, input logic [2:0] rid, input logic pid,
                               input logic [3:0] op, input int full_cyc, input bit bubble,
                               input int abort_at);
    int n;
    int k;
    int guard;
    bit v;
    n = (1 << l2) / 8;
    for (int i = 0; i < 512; i++) ram_img[i] = '0;

    @(negedge clk);
    log2_len    = 5'(l2);
    cmd_valid   = 1'b1;
    cmd_rlwe_id = rid;
    cmd_poly_id = pid;
    cmd_opcode  = op;
    fifo_full   = (full_cyc > 0);
    in_valid    = 1'b0;
    #1 checkOutput("idle_cmd_ready", val_t'(cmd_ready), val_t'(1));

    @(negedge clk);
    cmd_valid   = 1'b0;
    cmd_rlwe_id = ~rid;
    cmd_poly_id = ~pid;
    cmd_opcode  = ~op;
    in_valid    = 1'b1;
    #1;
    checkOutput("wait_busy", val_t'(busy), val_t'(1));
    checkOutput("wait_cmd_ready", val_t'(cmd_ready), val_t'(0));
    checkOutput("wait_in_ready", val_t'(in_ready), val_t'(0));
    checkOutput("wait_word_sel", val_t'(word_selA), val_t'(0));
    checkOutput("tag_rlwe_id", val_t'(rlwe_id), val_t'(rid));
    checkOutput("tag_poly_id", val_t'(poly_id), val_t'(pid));
    checkOutput("tag_opcode", val_t'(opcode), val_t'(op));

    for (int i = 1; i <= full_cyc; i++) begin
      @(negedge clk);
      fifo_full = (i < full_cyc);
      in_valid  = 1'b1;
      #1;
      checkOutput("full_in_ready", val_t'(in_ready), val_t'(0));
      checkOutput("full_word_sel", val_t'(word_selA), val_t'(0));
    end

    k = 0;
    guard = 0;
    while (k < n && guard < 4 * n + 8) begin
      @(negedge clk);
      guard++;
      if (k == abort_at) begin
        rst      = 1'b1;
        in_valid = 1'b1;
        #1;
        checkOutput("abort_wr_finish", val_t'(wr_finish), val_t'(1));
        checkOutput("abort_busy", val_t'(busy), val_t'(0));
        checkOutput("abort_in_ready", val_t'(in_ready), val_t'(0));
        checkOutput("abort_word_sel", val_t'(word_selA), val_t'(0));
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        return;
      end
      v = !bubble || (guard % 2 == 1);
      in_valid = v;
      in_data  = beat_data(k);
      if (full_cyc > 0 && k >= 5) fifo_full = 1'b1;
      #1;
      checkOutput("write_in_ready", val_t'(in_ready), val_t'(1));
      if (v) begin
        checkOutput("beat_word_selA", val_t'(word_selA), val_t'(4'hF));
        checkOutput("beat_word_selB", val_t'(word_selB), val_t'(4'hF));
        checkOutput("beat_addrA", val_t'(addrA), val_t'(2 * k));
        checkOutput("beat_addrB", val_t'(addrB), val_t'(2 * k + 1));
        ram_img[addrA] = dA;
        ram_img[addrB] = dB;
        k++;
      end else begin
        checkOutput("bubble_word_selA", val_t'(word_selA), val_t'(0));
        checkOutput("bubble_word_selB", val_t'(word_selB), val_t'(0));
      end
    end
    if (k < n) checkOutput("beat_timeout", val_t'(k), val_t'(n));

    @(negedge clk);
    in_valid  = 1'b1;
    fifo_full = 1'b0;
    #1;
    checkOutput("commit_wr_finish", val_t'(wr_finish), val_t'(0));
    checkOutput("commit_busy", val_t'(busy), val_t'(1));
    checkOutput("commit_in_ready", val_t'(in_ready), val_t'(0));
    checkOutput("commit_word_sel", val_t'(word_selA), val_t'(0));
    checkOutput("commit_poly_id", val_t'(poly_id), val_t'(pid));
    checkOutput("commit_rlwe_id", val_t'(rlwe_id), val_t'(rid));
    checkOutput("commit_opcode", val_t'(opcode), val_t'(op));

    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkOutput("settle_wr_finish", val_t'(wr_finish), val_t'(1));
    checkOutput("settle_busy", val_t'(busy), val_t'(1));
    checkOutput("settle_poly_id", val_t'(poly_id), val_t'(pid));

    @(negedge clk);
    #1;
    checkOutput("done_busy", val_t'(busy), val_t'(0));
    checkOutput("done_cmd_ready", val_t'(cmd_ready), val_t'(1));

    for (int l = 0; l < 2 * n; l++)
      checkOutput("ram_line", val_t'(ram_img[l]), val_t'(golden_line(l)));
  endtask

  initial begin
    int lows;
    rst         = 1'b1;
    log2_len    = 5'd11;
    cmd_valid   = 1'b0;
    cmd_rlwe_id = '0;
    cmd_poly_id = 1'b0;
    cmd_opcode  = '0;
    in_valid    = 1'b0;
    in_data     = '0;
    fifo_full   = 1'b0;

    @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b1;
    in_valid  = 1'b1;
    in_data   = beat_data(7);
    #1;
    checkOutput("rst_wr_finish", val_t'(wr_finish), val_t'(1));
    checkOutput("rst_word_selA", val_t'(word_selA), val_t'(0));
    checkOutput("rst_word_selB", val_t'(word_selB), val_t'(0));
    checkOutput("rst_addrA", val_t'(addrA), val_t'(0));
    checkOutput("rst_addrB", val_t'(addrB), val_t'(0));
    checkOutput("rst_dA", val_t'(dA), val_t'(0));
    checkOutput("rst_dB", val_t'(dB), val_t'(0));
    checkOutput("rst_tags", val_t'({rlwe_id, poly_id, opcode}), val_t'(0));
    checkOutput("rst_in_ready", val_t'(in_ready), val_t'(0));
    checkOutput("rst_cmd_ready", val_t'(cmd_ready), val_t'(0));
    checkOutput("rst_busy", val_t'(busy), val_t'(0));
    @(negedge clk);
    rst       = 1'b0;
    cmd_valid = 1'b0;
    in_valid  = 1'b0;

    applyStimulus(11, 3'd3, 1'b0, 4'h5, 0, 1'b0, -1);
    checkOutput("basic_commit_count", val_t'(low_cyc.size()), val_t'(1));

    applyStimulus(11, 3'd1, 1'b1, 4'hA, 20, 1'b0, -1);
    checkOutput("full_commit_count", val_t'(low_cyc.size()), val_t'(2));

    applyStimulus(11, 3'd2, 1'b0, 4'h3, 0, 1'b1, -1);

    lows = low_cyc.size();
    applyStimulus(11, 3'd4, 1'b0, 4'h6, 0, 1'b0, -1);
    applyStimulus(11, 3'd4, 1'b1, 4'h6, 0, 1'b0, -1);
    checkOutput("b2b_commit_count", val_t'(low_cyc.size() - lows), val_t'(2));
    if (low_cyc.size() - lows == 2) begin
      checkOutput("b2b_gap_ok", val_t'(low_cyc[lows+1] - low_cyc[lows] >= 259), val_t'(1));
      checkOutput("b2b_first_pid", val_t'(low_pid[lows]), val_t'(0));
      checkOutput("b2b_second_pid", val_t'(low_pid[lows+1]), val_t'(1));
    end

    lows = low_cyc.size();
    applyStimulus(11, 3'd5, 1'b0, 4'h1, 0, 1'b0, 100);
    checkOutput("abort_no_commit", val_t'(low_cyc.size() - lows), val_t'(0));
    applyStimulus(11, 3'd6, 1'b1, 4'h2, 0, 1'b0, -1);
    checkOutput("restart_commit", val_t'(low_cyc.size() - lows), val_t'(1));

    lows = low_cyc.size();
    applyStimulus(2, 3'd7, 1'b0, 4'hF, 0, 1'b0, -1);
    checkOutput("zero_len_commit", val_t'(low_cyc.size() - lows), val_t'(1));

    applyStimulus(3, 3'd1, 1'b1, 4'h9, 3, 1'b0, -1);
    checkOutput("one_beat_commit", val_t'(low_cyc.size() - lows), val_t'(2));

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
